// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared types and helpers for the flush/redirect controller.
// Holds the FSM encodings, the TLB-refill exception code and the redirect target selector.
package flush_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    FRC_IDLE  = 2'd0,
    FRC_DRAIN = 2'd1,
    FRC_REDIR = 2'd2
  } frc_state_e;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Exception beats ertn, which beats refetch; refill exceptions use their own entry.
  function automatic logic [31:0] frc_target(
    input logic        ex,
    input logic [5:0]  ecode,
    input logic        ertn,
    input logic [31:0] pc,
    input logic [31:0] eentry,
    input logic [31:0] tlbrentry,
    input logic [31:0] era,
    input logic [31:0] ofs
  );
    if (ex) begin
      return (ecode == ECODE_TLBR) ? tlbrentry : eentry;
    end else if (ertn) begin
      return era;
    end else begin
      return pc + ofs;
    end
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_if.sv
// IF-stage side of the flush/redirect controller: fetch bookkeeping, flush and redirect handshake.
// The master modport is the controller and the slave modport is the IF stage.
interface flush_redirect_ctrl_if;

  logic        if_req_fire;
  logic        if_resp_fire;
  logic        if_req_allow;
  logic        if_resp_discard;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    input  if_req_fire,
    input  if_resp_fire,
    input  redirect_ready,
    output if_req_allow,
    output if_resp_discard,
    output flush,
    output redirect_valid,
    output redirect_pc
  );

  modport slave (
    output if_req_fire,
    output if_resp_fire,
    output redirect_ready,
    input  if_req_allow,
    input  if_resp_discard,
    input  flush,
    input  redirect_valid,
    input  redirect_pc
  );

endinterface

// File: rtl/flush_redirect_ctrl_fetch_outst_cnt.sv
// Saturating up/down counter of accepted-but-unanswered instruction fetches.
// A response with nothing outstanding is a protocol error and leaves the count at zero.
module fetch_outst_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_d_o,
  output logic         full_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != {W{1'b1}}) begin
      cnt_d = cnt_q + W'(1);
    end else if (!inc_i && dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_d_o = cnt_d;
  assign full_o  = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Pipeline flush and fetch-redirect controller: one flush per WB event, drain of flushed
// fetch responses, then a valid/ready redirect of the IF stage to the new PC.
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int          OUTST_W     = 2,
  parameter logic [31:0] REFETCH_OFS = 32'd4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wb_ex_i,
  input  logic [5:0]                  wb_ecode_i,
  input  logic                        ertn_flush_i,
  input  logic                        wb_refetch_flush_i,
  input  logic [31:0]                 wb_pc_i,
  input  logic [31:0]                 csr_eentry_i,
  input  logic [31:0]                 csr_tlbrentry_i,
  input  logic [31:0]                 csr_era_i,
  flush_redirect_ctrl_if.master       fif
);

  frc_state_e          state_q;
  logic [OUTST_W-1:0]  discard_cnt_q;
  logic [OUTST_W-1:0]  outst_d;
  logic                outst_full;
  logic                redirect_valid_q;
  logic [31:0]         redirect_pc_q;
  logic [31:0]         redirect_pc_d;
  logic                ev;
  logic                flush;

  fetch_outst_cnt #(.W(OUTST_W)) u_outst (
    .clk     (clk),
    .resetn  (resetn),
    .inc_i   (fif.if_req_fire),
    .dec_i   (fif.if_resp_fire),
    .cnt_d_o (outst_d),
    .full_o  (outst_full)
  );

  assign ev            = wb_ex_i | ertn_flush_i | wb_refetch_flush_i;
  assign flush         = ev & (state_q == FRC_IDLE);
  assign redirect_pc_d = frc_target(wb_ex_i, wb_ecode_i, ertn_flush_i, wb_pc_i,
                                    csr_eentry_i, csr_tlbrentry_i, csr_era_i, REFETCH_OFS);

  // Events outside IDLE are ignored: the pipeline is already empty behind the flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= FRC_IDLE;
      discard_cnt_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        FRC_IDLE: begin
          if (ev) begin
            discard_cnt_q <= outst_d;
            redirect_pc_q <= redirect_pc_d;
            if (outst_d != '0) begin
              state_q <= FRC_DRAIN;
            end else begin
              state_q          <= FRC_REDIR;
              redirect_valid_q <= 1'b1;
            end
          end
        end
        FRC_DRAIN: begin
          if (fif.if_resp_fire) begin
            discard_cnt_q <= discard_cnt_q - OUTST_W'(1);
            if (discard_cnt_q == OUTST_W'(1)) begin
              state_q          <= FRC_REDIR;
              redirect_valid_q <= 1'b1;
            end
          end
        end
        FRC_REDIR: begin
          if (fif.redirect_ready) begin
            state_q          <= FRC_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= FRC_IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fif.flush           = flush;
  assign fif.if_req_allow    = (state_q == FRC_IDLE) & ~flush & ~outst_full;
  assign fif.if_resp_discard = fif.if_resp_fire & ((state_q == FRC_DRAIN) | flush);
  assign fif.redirect_valid  = redirect_valid_q;
  assign fif.redirect_pc     = redirect_pc_q;

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed bench for flush_redirect_ctrl: expected flush/discard/redirect events go into a
// scoreboard queue and a negedge monitor matches them against what the DUT presents.
module tb_flush_redirect_ctrl;

  localparam int EV_FLUSH    = 0;
  localparam int EV_DISCARD  = 1;
  localparam int EV_REDIRECT = 2;

  localparam logic [31:0] EENTRY    = 32'h1C00_8000;
  localparam logic [31:0] TLBRENTRY = 32'h1C00_F000;
  localparam logic [31:0] ERA       = 32'h1C00_0100;
  localparam logic [31:0] WBPC      = 32'h1C00_0040;

  typedef struct {
    int          kind;
    logic [31:0] pc;
  } expEvent_t;

  logic        clk;
  logic        resetn;
  logic        wbEx;
  logic [5:0]  wbEcode;
  logic        ertnFlush;
  logic        wbRefetch;
  logic [31:0] wbPc;
  logic [31:0] csrEentry;
  logic [31:0] csrTlbrentry;
  logic [31:0] csrEra;

  int checkCount;
  int failCount;
  expEvent_t expQ[$];

  flush_redirect_ctrl_if fif ();

  flush_redirect_ctrl #(.OUTST_W(2), .REFETCH_OFS(32'd4)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .wb_ex_i            (wbEx),
    .wb_ecode_i         (wbEcode),
    .ertn_flush_i       (ertnFlush),
    .wb_refetch_flush_i (wbRefetch),
    .wb_pc_i            (wbPc),
    .csr_eentry_i       (csrEentry),
    .csr_tlbrentry_i    (csrTlbrentry),
    .csr_era_i          (csrEra),
    .fif                (fif.master)
  );

  // 10-unit clock; inputs change 1 unit after posedge, everything is sampled at negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input int kind, input logic [31:0] pc);
    expEvent_t e;
    e.kind = kind;
    e.pc   = pc;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkEvent(input int kind, input logic [31:0] pc);
    expEvent_t e;
    checkCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_unexpected: got kind=%0d pc=0x%08h expected no event at %0t",
               kind, pc, $time);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.pc !== pc) begin
        failCount++;
        $display("[TB] FAIL scoreboard_event: got kind=%0d pc=0x%08h expected kind=%0d pc=0x%08h at %0t",
                 kind, pc, e.kind, e.pc, $time);
      end
    end
  endtask

  // Monitor: every flush, discarded response and accepted redirect must match the queue head.
  always @(negedge clk) begin
    if (resetn) begin
      if (fif.flush)                               checkEvent(EV_FLUSH, 32'h0);
      if (fif.if_resp_discard)                     checkEvent(EV_DISCARD, 32'h0);
      if (fif.redirect_valid && fif.redirect_ready) checkEvent(EV_REDIRECT, fif.redirect_pc);
    end
  end

  task automatic applyStimulus(input logic ex, input logic [5:0] ecode, input logic ertn,
                               input logic refetch, input logic req, input logic resp,
                               input logic ready);
    @(posedge clk);
    #1;
    wbEx               = ex;
    wbEcode            = ecode;
    ertnFlush          = ertn;
    wbRefetch          = refetch;
    fif.if_req_fire    = req;
    fif.if_resp_fire   = resp;
    fif.redirect_ready = ready;
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic ready);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, ready);
  endtask

  task automatic issueFetches(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checkCount         = 0;
    failCount          = 0;
    resetn             = 1'b0;
    wbEx               = 1'b0;
    wbEcode            = 6'h0;
    ertnFlush          = 1'b0;
    wbRefetch          = 1'b0;
    wbPc               = WBPC;
    csrEentry          = EENTRY;
    csrTlbrentry       = TLBRENTRY;
    csrEra             = ERA;
    fif.if_req_fire    = 1'b0;
    fif.if_resp_fire   = 1'b0;
    fif.redirect_ready = 1'b0;

    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("rst_redirect_valid", {31'b0, fif.redirect_valid}, 32'h0);
    checkOutput("rst_redirect_pc", fif.redirect_pc, 32'h0);
    resetn = 1'b1;
    idleCycle(1'b0);
    checkOutput("rst_flush", {31'b0, fif.flush}, 32'h0);
    checkOutput("rst_req_allow", {31'b0, fif.if_req_allow}, 32'h1);
    checkOutput("rst_resp_discard", {31'b0, fif.if_resp_discard}, 32'h0);

    // Exception with nothing outstanding: redirect straight after the flush cycle.
    pushExp(EV_FLUSH, 32'h0);
    pushExp(EV_REDIRECT, EENTRY);
    applyStimulus(1'b1, 6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_flush", {31'b0, fif.flush}, 32'h1);
    checkOutput("t1_allow_n", {31'b0, fif.if_req_allow}, 32'h0);
    checkOutput("t1_valid_n", {31'b0, fif.redirect_valid}, 32'h0);
    idleCycle(1'b1);
    checkOutput("t1_valid_n1", {31'b0, fif.redirect_valid}, 32'h1);
    checkOutput("t1_pc", fif.redirect_pc, EENTRY);
    checkOutput("t1_flush_n1", {31'b0, fif.flush}, 32'h0);
    idleCycle(1'b0);
    checkOutput("t1_valid_idle", {31'b0, fif.redirect_valid}, 32'h0);
    checkOutput("t1_allow_idle", {31'b0, fif.if_req_allow}, 32'h1);

    // TLB refill exception picks tlbrentry.
    pushExp(EV_FLUSH, 32'h0);
    pushExp(EV_REDIRECT, TLBRENTRY);
    applyStimulus(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1);
    checkOutput("t2_pc", fif.redirect_pc, TLBRENTRY);
    idleCycle(1'b0);

    // ertn with two fetches in flight: both responses discarded, fetch held throughout.
    issueFetches(2);
    pushExp(EV_FLUSH, 32'h0);
    pushExp(EV_DISCARD, 32'h0);
    pushExp(EV_DISCARD, 32'h0);
    pushExp(EV_REDIRECT, ERA);
    applyStimulus(1'b0, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_flush", {31'b0, fif.flush}, 32'h1);
    idleCycle(1'b0);
    checkOutput("t3_allow_d0", {31'b0, fif.if_req_allow}, 32'h0);
    checkOutput("t3_valid_d0", {31'b0, fif.redirect_valid}, 32'h0);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_allow_d1", {31'b0, fif.if_req_allow}, 32'h0);
    checkOutput("t3_valid_d1", {31'b0, fif.redirect_valid}, 32'h0);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_allow_d2", {31'b0, fif.if_req_allow}, 32'h0);
    checkOutput("t3_valid_d2", {31'b0, fif.redirect_valid}, 32'h0);
    idleCycle(1'b0);
    checkOutput("t3_valid_redir", {31'b0, fif.redirect_valid}, 32'h1);
    checkOutput("t3_pc", fif.redirect_pc, ERA);
    checkOutput("t3_allow_redir", {31'b0, fif.if_req_allow}, 32'h0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("t3_allow_idle", {31'b0, fif.if_req_allow}, 32'h1);

    // Exception and refetch together: one flush, exception target wins.
    pushExp(EV_FLUSH, 32'h0);
    pushExp(EV_REDIRECT, EENTRY);
    applyStimulus(1'b1, 6'h0B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1);
    checkOutput("t4_pc", fif.redirect_pc, EENTRY);
    checkOutput("t4_flush_n1", {31'b0, fif.flush}, 32'h0);
    idleCycle(1'b0);

    // Refetch with request and response in the flush cycle: one fetch left to drain.
    issueFetches(1);
    pushExp(EV_FLUSH, 32'h0);
    pushExp(EV_DISCARD, 32'h0);
    pushExp(EV_DISCARD, 32'h0);
    pushExp(EV_REDIRECT, WBPC + 32'd4);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_discard_n", {31'b0, fif.if_resp_discard}, 32'h1);
    idleCycle(1'b0);
    checkOutput("t5_valid_drain", {31'b0, fif.redirect_valid}, 32'h0);
    checkOutput("t5_allow_drain", {31'b0, fif.if_req_allow}, 32'h0);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b1);
    checkOutput("t5_pc", fif.redirect_pc, WBPC + 32'd4);
    idleCycle(1'b0);

    // Reset in the middle of a drain with two responses still owed.
    issueFetches(2);
    pushExp(EV_FLUSH, 32'h0);
    applyStimulus(1'b1, 6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0);
    checkOutput("t6_allow_drain", {31'b0, fif.if_req_allow}, 32'h0);
    resetn = 1'b0;
    idleCycle(1'b0);
    resetn = 1'b1;
    idleCycle(1'b0);
    checkOutput("t6_valid_post", {31'b0, fif.redirect_valid}, 32'h0);
    checkOutput("t6_allow_post", {31'b0, fif.if_req_allow}, 32'h1);
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_stray_discard", {31'b0, fif.if_resp_discard}, 32'h0);
    issueFetches(3);
    checkOutput("t6_allow_at2", {31'b0, fif.if_req_allow}, 32'h1);
    idleCycle(1'b0);
    checkOutput("t6_allow_full", {31'b0, fif.if_req_allow}, 32'h0);

    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("queue_empty", expQ.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
